// File: rtl/adder_tree_arbiter_pkg.sv
// Shared constants, id type and width helper for the shared 8-operand adder tree.
package adder_tree_pkg;

  localparam int OPS    = 8;
  localparam int LEVELS = 3;

  typedef logic [3:0] req_id_t;

  function automatic int sum_w(input int w);
    return w + LEVELS;
  endfunction

endpackage

// File: rtl/adder_tree_arbiter_pipe.sv
// Registered-input, registered-output 3-level unsigned adder tree; latency 2 from load.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [OPS*W-1:0]      ops,
  output logic [sum_w(W)-1:0]   sum
);

  logic [OPS*W-1:0] ops_q;
  logic [W:0]       lvl1 [4];
  logic [W+1:0]     lvl2 [2];
  logic [W+2:0]     lvl3;

  // Each level widens by one bit so the full-scale sum never wraps.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = {1'b0, ops_q[(2*i)*W +: W]} + {1'b0, ops_q[(2*i+1)*W +: W]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    end
    lvl3 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= '0;
      sum   <= '0;
    end else begin
      if (load) ops_q <= ops;
      sum <= lvl3;
    end
  end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin sharing of one pipelined adder tree with a credit-protected result FIFO.
// Optional stall counter port is built when ADDER_ARB_STATS_EN is defined.
module adder_tree_arbiter
  import adder_tree_pkg::*;
#(
  parameter int  ADDER_WIDTH = 5,
  parameter int  NUM_REQ     = 4,
  parameter int  RES_DEPTH   = 4,
  localparam int ID_W        = $clog2(NUM_REQ),
  localparam int SUM_W       = sum_w(ADDER_WIDTH),
  localparam int VEC_W       = OPS * ADDER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ID_W-1:0]          res_id,
  output logic [SUM_W-1:0]         res_sum
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CRD_W = PTR_W + 1;

  req_id_t          rr_ptr, winner, hi_idx, lo_idx;
  logic             hi_hit, lo_hit, any_valid;
  logic [CRD_W-1:0] credit;
  logic             issue_allowed, handshake, push, pop;
  logic [VEC_W-1:0] tree_ops;
  logic [SUM_W-1:0] tree_sum;
  logic             tag1_valid, tag2_valid;
  logic [ID_W-1:0]  tag1_id, tag2_id;
  logic [ID_W-1:0]  mem_id  [RES_DEPTH];
  logic [SUM_W-1:0] mem_sum [RES_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;

  assign issue_allowed = (credit < CRD_W'(RES_DEPTH));

  // Lowest valid index above rr_ptr wins; if none, wrap to the lowest valid index overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_hit = 1'b1;
        lo_idx = req_id_t'(i);
        if (req_id_t'(i) > rr_ptr) begin
          hi_hit = 1'b1;
          hi_idx = req_id_t'(i);
        end
      end
    end
    any_valid = lo_hit;
    winner    = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    req_ready = '0;
    tree_ops  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue_allowed && any_valid && (winner == req_id_t'(i))) begin
        req_ready[i] = 1'b1;
        tree_ops     = req_data[i*VEC_W +: VEC_W];
      end
    end
  end

  assign handshake = |(req_valid & req_ready);
  assign push      = tag2_valid;
  assign pop       = res_valid && res_ready;

  adder_tree_pipe #(.W(ADDER_WIDTH)) u_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (handshake),
    .ops   (tree_ops),
    .sum   (tree_sum)
  );

  // Credit covers every vector from grant until its result leaves the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= req_id_t'(NUM_REQ - 1);
      credit     <= '0;
      tag1_valid <= 1'b0;
      tag2_valid <= 1'b0;
      tag1_id    <= '0;
      tag2_id    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (handshake) rr_ptr <= winner;
      if (handshake && !pop) credit <= credit + 1'b1;
      else if (!handshake && pop) credit <= credit - 1'b1;
      tag1_valid <= handshake;
      tag1_id    <= winner[ID_W-1:0];
      tag2_valid <= tag1_valid;
      tag2_id    <= tag1_id;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr[PTR_W-1:0]]  <= tag2_id;
      mem_sum[wr_ptr[PTR_W-1:0]] <= tree_sum;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign res_valid  = !fifo_empty;
  assign res_id     = res_valid ? mem_id[rd_ptr[PTR_W-1:0]]  : '0;
  assign res_sum    = res_valid ? mem_sum[rd_ptr[PTR_W-1:0]] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

`ifdef ADDER_ARB_STATS_EN
  // Counts cycles where some requester waits only because credit is exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (|req_valid && !issue_allowed && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Randomized bench for adder_tree_arbiter against a queue-based reference model.
module tb_adder_tree_arbiter;

  localparam int W  = 5;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int VW = 8 * W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*VW-1:0] req_data;
  logic            res_valid, res_ready;
  logic [1:0]      res_id;
  logic [7:0]      res_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  adder_tree_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .RES_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int vis;
  } pend_t;

  pend_t    pend[$];
  int       tests = 0;
  int       fails = 0;
  int       cyc   = 0;
  int       m_ptr = N - 1;
  int       m_stall = 0;
  int       exp_win, exp_id, exp_sum;
  logic [N-1:0] exp_ready;
  logic     exp_valid, exp_stall_inc;

  function automatic int vec_sum(input int r);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'(req_data[r*VW + k*W +: W]);
    return s;
  endfunction

  // Expected outputs for the current cycle, from spec-level rules.
  task automatic model_eval();
    bit allowed;
    #1;
    allowed = pend.size() < D;
    exp_win = -1;
    for (int k = 1; k <= N; k++) begin
      int idx = (m_ptr + k) % N;
      if (exp_win < 0 && req_valid[idx]) exp_win = idx;
    end
    exp_ready     = (allowed && exp_win >= 0) ? (N'(1) << exp_win) : '0;
    exp_valid     = (pend.size() > 0) && (cyc >= pend[0].vis);
    exp_id        = exp_valid ? pend[0].id  : 0;
    exp_sum       = exp_valid ? pend[0].sum : 0;
    exp_stall_inc = (|req_valid) && !allowed;
  endtask

  task automatic tick();
    int s = 0;
    if (exp_ready != '0) s = vec_sum(exp_win);
    @(posedge clk);
    cyc++;
    if (exp_valid && res_ready) void'(pend.pop_front());
    if (exp_ready != '0) begin
      pend.push_back('{id: exp_win, sum: s, vis: cyc + 2});
      m_ptr = exp_win;
    end
    if (exp_stall_inc && m_stall < 65535) m_stall++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pend.delete();
    m_ptr = N - 1;
    m_stall = 0;
    rst_n = 1'b1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N * 8; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_data = '0;
    @(negedge clk);
    #1;
    tests++;
    if (res_valid !== 1'b0 || res_id !== 2'd0 || res_sum !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got v=%b id=%0d sum=%0d want 0/0/0", res_valid, res_id, res_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 7; c++) begin
      randomize_data();
      model_eval();
      tests++;
      if (req_ready !== exp_ready) begin
        fails++;
        $display("[TB] FAIL reset_pre_grant got %b want %b", req_ready, exp_ready);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (res_valid !== 1'b0 || res_id !== 2'd0 || res_sum !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_midstream got v=%b id=%0d sum=%0d want 0/0/0", res_valid, res_id, res_sum);
    end
`ifdef ADDER_ARB_STATS_EN
    tests++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_stall got %0d want 0", stall_cnt);
    end
`endif
    pend.delete();
    m_ptr = N - 1;
    m_stall = 0;
    rst_n = 1'b1;
    model_eval();
    tests++;
    if (req_ready !== 4'b0001 || req_ready !== exp_ready) begin
      fails++;
      $display("[TB] FAIL reset_first_grant got %b want 0001", req_ready);
    end
    req_valid = '0;
    model_eval();
    tick();
  endtask

  task automatic test_single();
    int lat = -1;
    int got_id = -1;
    int got_sum = -1;
    res_ready = 1'b1;
    randomize_data();
    req_data[2*VW +: VW] = {8{5'h1F}};
    req_valid = 4'b0100;
    model_eval();
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL single_grant got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      model_eval();
      if (res_valid === 1'b1 && lat < 0) begin
        lat = k;
        got_id = int'(res_id);
        got_sum = int'(res_sum);
      end
      tick();
    end
    tests++;
    if (lat != 3 || got_id != 2 || got_sum != 'hF8) begin
      fails++;
      $display("[TB] FAIL single_result got lat=%0d id=%0d sum=%0h want 3/2/f8", lat, got_id, got_sum);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    res_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      randomize_data();
      model_eval();
      tests++;
      if (req_ready !== (N'(1) << (c % N))) begin
        fails++;
        $display("[TB] FAIL rr_order c=%0d got %b want %b", c, req_ready, N'(1) << (c % N));
      end
      tests++;
      if (res_valid !== exp_valid || (exp_valid && (res_id !== 2'(exp_id) || res_sum !== 8'(exp_sum)))) begin
        fails++;
        $display("[TB] FAIL rr_result c=%0d got v=%b id=%0d sum=%0d want v=%b id=%0d sum=%0d",
                 c, res_valid, res_id, res_sum, exp_valid, exp_id, exp_sum);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    int order[$];
    apply_reset();
    res_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      randomize_data();
      model_eval();
      if (|(req_ready & req_valid)) hs++;
      tick();
    end
    model_eval();
    tests++;
    if (hs != 4 || req_ready !== '0) begin
      fails++;
      $display("[TB] FAIL bp_stall got hs=%0d ready=%b want hs=4 ready=0000", hs, req_ready);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      randomize_data();
      model_eval();
      if (res_valid === 1'b1) order.push_back(int'(res_id));
      tests++;
      if (req_ready !== exp_ready || res_valid !== exp_valid ||
          (exp_valid && (res_id !== 2'(exp_id) || res_sum !== 8'(exp_sum)))) begin
        fails++;
        $display("[TB] FAIL bp_drain c=%0d got r=%b v=%b id=%0d sum=%0d want r=%b v=%b id=%0d sum=%0d",
                 c, req_ready, res_valid, res_id, res_sum, exp_ready, exp_valid, exp_id, exp_sum);
      end
      tick();
    end
    tests++;
    if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
      fails++;
      $display("[TB] FAIL bp_order got n=%0d want first ids 0,1,2,3", order.size());
    end
  endtask

  task automatic test_toggle();
    int issued[N];
    int got[N];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      got[i] = 0;
      for (int k = 0; k < 8; k++) req_data[i*VW + k*W +: W] = W'(k);
    end
    for (int c = 0; c < 48; c++) begin
      req_valid = (c < 40) ? N'($urandom_range(1, 15)) : '0;
      res_ready = (c >= 40) || (c % 2 == 0);
      model_eval();
      if (exp_ready != '0) issued[exp_win]++;
      if (res_valid === 1'b1 && res_ready) begin
        got[res_id]++;
        tests++;
        if (res_sum !== 8'd28) begin
          fails++;
          $display("[TB] FAIL toggle_sum c=%0d got %0d want 28", c, res_sum);
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got[i] != issued[i]) begin
        fails++;
        $display("[TB] FAIL toggle_count id=%0d got %0d want %0d", i, got[i], issued[i]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      randomize_data();
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      model_eval();
      tests++;
      if (req_ready !== exp_ready || res_valid !== exp_valid ||
          (exp_valid && (res_id !== 2'(exp_id) || res_sum !== 8'(exp_sum)))) begin
        fails++;
        $display("[TB] FAIL random c=%0d got r=%b v=%b id=%0d sum=%0d want r=%b v=%b id=%0d sum=%0d",
                 c, req_ready, res_valid, res_id, res_sum, exp_ready, exp_valid, exp_id, exp_sum);
      end
      tick();
    end
  endtask

`ifdef ADDER_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    res_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 14; c++) begin
      randomize_data();
      model_eval();
      tick();
    end
    #1;
    tests++;
    if (stall_cnt !== 16'd10 || int'(stall_cnt) != m_stall) begin
      fails++;
      $display("[TB] FAIL stats_count got %0d want 10", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_toggle();
    test_random();
`ifdef ADDER_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
